// File: rtl/wb_interconnect.sv
// wb_interconnect: shared-bus Wishbone interconnect with round-robin master
// arbitration and address decode onto NUM_SLAVES slaves. Unmapped accesses
// return a one-cycle error pulse.
// Optional watchdog: define WB_INTERCONNECT_TIMEOUT_EN to error out accesses
// whose slave has not acknowledged within TIMEOUT_CYCLES strobed cycles.
module wb_interconnect #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_SEL_WIDTH   = 4,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_E000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_o,
  output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  s_addr_o,
  output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_o,
  output logic [NUM_SLAVES*WB_SEL_WIDTH-1:0]   s_sel_o,
  output logic [NUM_SLAVES-1:0]                s_we_o,
  output logic [NUM_SLAVES-1:0]                s_stb_o,
  output logic [NUM_SLAVES-1:0]                s_cyc_o,
  input  logic [NUM_SLAVES-1:0]                s_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_i
);

  localparam int unsigned MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic {ST_IDLE, ST_GRANTED} state_e;

  state_e                     state_q, state_d;
  logic [MIW-1:0]             grant_idx_q, grant_idx_d;
  logic [MIW-1:0]             last_grant_q, last_grant_d;
  logic                       err_q, err_d;
  logic                       grant_valid;
  logic                       arb_found;

  logic                       g_cyc, g_stb, g_we;
  logic [WB_ADDR_WIDTH-1:0]   g_addr;
  logic [WB_DATA_WIDTH-1:0]   g_wdata;
  logic [WB_SEL_WIDTH-1:0]    g_sel;

  logic                       hit;
  logic [SIW-1:0]             sel;
  logic                       s_ack_sel;
  logic [WB_DATA_WIDTH-1:0]   s_data_sel;
  logic                       wdog_fire;

  always_comb grant_valid = (state_q == ST_GRANTED);

  // Mux the granted master's request signals onto the shared bus
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_sel   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_q == MIW'(i)) begin
        g_cyc   = m_cyc_i[i];
        g_stb   = m_stb_i[i];
        g_we    = m_we_i[i];
        g_addr  = m_addr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        g_wdata = m_data_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        g_sel   = m_sel_i[i*WB_SEL_WIDTH +: WB_SEL_WIDTH];
      end
    end
  end

  // Round-robin arbiter: scan upward from last_grant+1, then wrap to 0
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    arb_found    = 1'b0;
    if (state_q == ST_IDLE) begin
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (!arb_found && (j > 32'(last_grant_q)) && m_cyc_i[j]) begin
          arb_found   = 1'b1;
          grant_idx_d = MIW'(j);
        end
      end
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (!arb_found && (j <= 32'(last_grant_q)) && m_cyc_i[j]) begin
          arb_found   = 1'b1;
          grant_idx_d = MIW'(j);
        end
      end
      if (arb_found) state_d = ST_GRANTED;
    end else if (!g_cyc) begin
      state_d      = ST_IDLE;
      last_grant_d = grant_idx_q;
    end
  end

  // Address decode; lowest matching slave index wins
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit && ((g_addr & SLAVE_MASK[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) ==
                   SLAVE_BASE[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])) begin
        hit = 1'b1;
        sel = SIW'(k);
      end
    end
  end

  // Select the decoded slave's response
  always_comb begin
    s_ack_sel  = 1'b0;
    s_data_sel = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (sel == SIW'(k)) begin
        s_ack_sel  = s_ack_i[k];
        s_data_sel = s_data_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog_q, wdog_d;
  logic          wdog_inc;

  // Watchdog: count strobed cycles without ack; fire on the last allowed one
  always_comb begin
    wdog_inc  = grant_valid & g_stb & hit & ~s_ack_sel & ~err_q;
    wdog_fire = wdog_inc && (wdog_q == TW'(TIMEOUT_CYCLES - 1));
    if (!grant_valid || !g_stb || s_ack_sel || err_q) wdog_d = '0;
    else if (wdog_inc)                                wdog_d = wdog_q + TW'(1);
    else                                              wdog_d = wdog_q;
  end

  // Watchdog counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  logic unused_timeout_cfg;

  // No watchdog: a silent slave stalls the bus; parameter kept referenced
  always_comb begin
    wdog_fire          = 1'b0;
    unused_timeout_cfg = ^TIMEOUT_CYCLES;
  end
`endif

  // Error pulse for unmapped addresses or watchdog expiry
  always_comb err_d = grant_valid & g_stb & ~err_q & (~hit | wdog_fire);

  // Arbiter and error state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= MIW'(NUM_MASTERS - 1);
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // Drive slave broadcast and master return paths; everything gated by grant
  always_comb begin
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = '0;
    s_stb_o  = '0;
    s_cyc_o  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_valid && (grant_idx_q == MIW'(i))) begin
        m_ack_o[i] = g_cyc & hit & s_ack_sel;
        m_err_o[i] = err_q;
      end
      m_data_o[i*WB_DATA_WIDTH +: WB_DATA_WIDTH] =
        (grant_valid && hit) ? s_data_sel : '0;
    end
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (grant_valid) begin
        s_addr_o[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH] = g_addr;
        s_data_o[k*WB_DATA_WIDTH +: WB_DATA_WIDTH] = g_wdata;
        s_sel_o[k*WB_SEL_WIDTH +: WB_SEL_WIDTH]    = g_sel;
        s_we_o[k]                                  = g_we;
        s_cyc_o[k] = g_cyc & hit & (sel == SIW'(k));
        s_stb_o[k] = g_stb & hit & (sel == SIW'(k)) & ~err_q;
      end
    end
  end

endmodule
